// File: rtl/sequence_player_pkg.sv
// Shared memory-game types: FSM states, the 2-bit symbol and its LED decode.
package sequence_player_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPEND,
    ST_SHOW_ON,
    ST_SHOW_OFF,
    ST_DONE
  } state_t;

  typedef logic [1:0] symbol_t;

  localparam int DEFAULT_ON_TICKS  = 4;
  localparam int DEFAULT_OFF_TICKS = 2;

  // Symbols 0..2 map to led[0..2]; 3 is never stored but still decodes one-hot.
  function automatic logic [2:0] led_decode(input symbol_t s);
    logic [2:0] v;
    v = 3'b001;
    case (s)
      2'd1:    v = 3'b010;
      2'd2:    v = 3'b100;
      default: v = 3'b001;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/sequence_player_pattern_mem.sv
// Pattern register file: synchronous write, two asynchronous read ports
// (one for the external checker, one for the playback FSM).
module pattern_mem
  import sequence_player_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  symbol_t       wr_data,
  input  logic [AW-1:0] rd_addr,
  output symbol_t       rd_data,
  input  logic [AW-1:0] play_addr,
  output symbol_t       play_data
);

  symbol_t words [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      symbol_t word_reg;
      always_ff @(posedge clk) begin
        if (wr_en && (wr_addr == AW'(gi))) begin
          word_reg <= wr_data;
        end
      end
      assign words[gi] = word_reg;
    end
  endgenerate

  assign rd_data   = words[rd_addr];
  assign play_data = words[play_addr];

endmodule

// File: rtl/sequence_player.sv
// Memory-game sequence player: appends one random symbol per round and
// replays the whole stored pattern on three one-hot LEDs, paced by tick.
module sequence_player
  import sequence_player_pkg::*;
#(
  parameter int  MAX_LEN   = 16,
  parameter int  ON_TICKS  = DEFAULT_ON_TICKS,
  parameter int  OFF_TICKS = DEFAULT_OFF_TICKS,
  localparam int AW        = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    rnd_in,
  output logic          rnd_en,
  input  logic          start,
  input  logic          clear,
  input  logic          tick,
  input  logic [AW-1:0] rd_addr,
  output logic [1:0]    rd_data,
  output logic [2:0]    led,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   seq_len,
  output logic          full
);

  localparam int TICK_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int CW       = $clog2(TICK_MAX + 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] tick_cnt_reg, tick_cnt_next;
  logic [AW-1:0] play_idx_reg, play_idx_next;
  logic [AW:0]   seq_len_reg, seq_len_next;
  logic [2:0]    led_reg, led_next;
  logic          rnd_en_reg;
  logic          wr_en;
  logic          full_w;
  symbol_t       wr_data, play_data, show_sym;

  assign full_w  = (seq_len_reg == (AW+1)'(MAX_LEN));
  assign wr_data = (rnd_in == 2'd3) ? 2'd0 : rnd_in;

  pattern_mem #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_mem (
    .clk       (clk),
    .wr_en     (wr_en),
    .wr_addr   (seq_len_reg[AW-1:0]),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .play_addr (play_idx_next),
    .play_data (play_data)
  );

  always_comb begin
    state_next    = state_reg;
    tick_cnt_next = tick_cnt_reg;
    play_idx_next = play_idx_reg;
    seq_len_next  = seq_len_reg;
    wr_en         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (clear) begin
          seq_len_next = '0;
        end else if (start) begin
          state_next = ST_APPEND;
        end
      end
      ST_APPEND: begin
        play_idx_next = '0;
        state_next    = ST_SHOW_ON;
        if (!full_w) begin
          wr_en        = 1'b1;
          seq_len_next = seq_len_reg + (AW+1)'(1);
        end
      end
      ST_SHOW_ON: begin
        if (tick) begin
          if (tick_cnt_reg == CW'(ON_TICKS - 1)) begin
            state_next = ST_SHOW_OFF;
          end else begin
            tick_cnt_next = tick_cnt_reg + CW'(1);
          end
        end
      end
      ST_SHOW_OFF: begin
        if (tick) begin
          if (tick_cnt_reg == CW'(OFF_TICKS - 1)) begin
            if ({1'b0, play_idx_reg} == (seq_len_reg - (AW+1)'(1))) begin
              state_next = ST_DONE;
            end else begin
              play_idx_next = play_idx_reg + AW'(1);
              state_next    = ST_SHOW_ON;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + CW'(1);
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    // Every state is entered with a fresh tick count.
    if (state_next != state_reg) begin
      tick_cnt_next = '0;
    end
  end

  // The first symbol of a fresh pattern is written in the same cycle the LED
  // register loads it, so forward the write data past the memory.
  always_comb begin
    show_sym = play_data;
    if (wr_en && (seq_len_reg[AW-1:0] == play_idx_next)) begin
      show_sym = wr_data;
    end
    led_next = (state_next == ST_SHOW_ON) ? led_decode(show_sym) : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      tick_cnt_reg <= '0;
      play_idx_reg <= '0;
      seq_len_reg  <= '0;
      led_reg      <= 3'b000;
      rnd_en_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick_cnt_next;
      play_idx_reg <= play_idx_next;
      seq_len_reg  <= seq_len_next;
      led_reg      <= led_next;
      rnd_en_reg   <= (state_next == ST_IDLE);
    end
  end

  assign led     = led_reg;
  assign rnd_en  = rnd_en_reg;
  assign busy    = (state_reg != ST_IDLE);
  assign done    = (state_reg == ST_DONE);
  assign seq_len = seq_len_reg;
  assign full    = full_w;

endmodule

// File: tb/tb_sequence_player.sv
// Scoreboard bench: stimulus pushes the expected LED symbols and round summaries,
// a negedge monitor pops and compares them as the player displays them.
module tb_sequence_player;

  localparam int MAX_LEN   = 4;
  localparam int ON_TICKS  = 2;
  localparam int OFF_TICKS = 1;
  localparam int AW        = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    rnd_in = 2'd0;
  logic          rnd_en;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic          tick = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [1:0]    rd_data;
  logic [2:0]    led;
  logic          busy;
  logic          done;
  logic [AW:0]   seq_len;
  logic          full;

  sequence_player #(
    .MAX_LEN   (MAX_LEN),
    .ON_TICKS  (ON_TICKS),
    .OFF_TICKS (OFF_TICKS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rnd_in  (rnd_in),
    .rnd_en  (rnd_en),
    .start   (start),
    .clear   (clear),
    .tick    (tick),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .led     (led),
    .busy    (busy),
    .done    (done),
    .seq_len (seq_len),
    .full    (full)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;
    int start_cyc;
    int exp_busy;
  } round_t;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  bit         tick_always = 1'b1;
  bit         round_active = 1'b0;
  int         model_pat[$];
  logic [2:0] exp_led[$];
  round_t     exp_round[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tick = tick_always ? 1'b1 : ($urandom_range(0, 2) == 0);
    end
  end

  // Monitor
  logic [2:0] prev_led = 3'b000;
  int         shown = 0, on_t = 0, dark_t = 0, busy_cnt = 0;
  logic [2:0] exp_m;
  round_t     r_m;

  always @(negedge clk) begin
    if (!reset) begin
      prev_led = 3'b000;
      shown = 0; on_t = 0; dark_t = 0; busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (led != 3'b000 && prev_led == 3'b000) begin
        check("led_onehot", 32'($onehot(led)), 1);
        if (exp_led.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_led: got %b expected dark", led);
        end else begin
          exp_m = exp_led.pop_front();
          check("led_symbol", led, exp_m);
          if (shown == 0) begin
            if (exp_round.size() > 0) check("first_led_latency", cyc - exp_round[0].start_cyc, 2);
          end else begin
            check("off_ticks", dark_t, OFF_TICKS);
          end
        end
        shown++; on_t = 0; dark_t = 0;
      end else if (led != 3'b000 && led != prev_led) begin
        tests++; fails++;
        $display("FAIL led_changed: got %b expected %b", led, prev_led);
      end
      if (led == 3'b000 && prev_led != 3'b000) check("on_ticks", on_t, ON_TICKS);
      if (led != 3'b000 && tick) on_t++;
      if (led == 3'b000 && shown > 0 && busy && !done && tick) dark_t++;
      if (done) begin
        if (exp_round.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got done expected idle");
        end else begin
          r_m = exp_round.pop_front();
          check("symbols_shown", shown, r_m.len);
          check("done_seq_len", seq_len, r_m.len);
          check("last_off_ticks", dark_t, OFF_TICKS);
          if (r_m.exp_busy >= 0) check("busy_cycles", busy_cnt, r_m.exp_busy);
        end
        $display("[TB] round done: %0d symbols shown, seq_len=%0d", shown, seq_len);
        shown = 0; busy_cnt = 0; dark_t = 0;
        round_active = 1'b0;
      end
      prev_led = led;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (round_active && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (round_active) begin
      tests++; fails++;
      $display("FAIL round_timeout: got busy expected done within 3000 cycles");
      round_active = 1'b0;
      exp_round.delete();
      exp_led.delete();
    end
  endtask

  task automatic do_round(input logic [1:0] sym);
    round_t     r;
    logic [2:0] l;
    wait_idle();
    @(posedge clk);
    #1;
    rnd_in = sym;
    start  = 1'b1;
    if (model_pat.size() < MAX_LEN) model_pat.push_back((sym == 2'd3) ? 0 : int'(sym));
    r.len       = model_pat.size();
    r.start_cyc = cyc;
    r.exp_busy  = tick_always ? (2 + r.len * (ON_TICKS + OFF_TICKS)) : -1;
    foreach (model_pat[i]) begin
      l = 3'b001 << model_pat[i];
      exp_led.push_back(l);
    end
    exp_round.push_back(r);
    round_active = 1'b1;
    $display("[TB] start rnd_in=%0d expected pattern length %0d", sym, r.len);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rnd_in = 2'($urandom_range(0, 3));
  endtask

  task automatic do_clear();
    wait_idle();
    @(posedge clk);
    #1;
    clear = 1'b1;
    model_pat.delete();
    @(posedge clk);
    #1;
    clear = 1'b0;
    $display("[TB] clear");
  endtask

  task automatic check_idle_state(input string tag);
    wait_idle();
    @(negedge clk);
    check({tag, "_seq_len"}, seq_len, model_pat.size());
    check({tag, "_full"}, full, (model_pat.size() == MAX_LEN));
    check({tag, "_busy"}, busy, 0);
    check({tag, "_led"}, led, 0);
    check({tag, "_rnd_en"}, rnd_en, 1);
    for (int a = 0; a < model_pat.size(); a++) begin
      rd_addr = AW'(a);
      #1;
      check({tag, "_rd_data"}, rd_data, model_pat[a]);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rnd_en", rnd_en, 0);
    check("rst_led", led, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("rel_seq_len", seq_len, 0);
    check("rel_done", done, 0);
    check("rel_full", full, 0);
    @(negedge clk);
    check("rel_rnd_en", rnd_en, 1);

    do_round(2'd2);
    check_idle_state("single");

    do_clear();
    do_round(2'd1);
    do_round(2'd0);
    do_round(2'd2);
    check_idle_state("three");

    do_round(2'd3);
    check_idle_state("sym3");
    do_round(2'd1);
    check_idle_state("full_replay");

    // start and clear while busy are both dropped
    do_clear();
    do_round(2'd2);
    start = 1'b1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    clear = 1'b0;
    check_idle_state("busy_ignore");

    // start and clear together in IDLE: clear wins, nothing plays
    wait_idle();
    @(posedge clk);
    #1;
    start = 1'b1;
    clear = 1'b1;
    model_pat.delete();
    @(posedge clk);
    #1;
    start = 1'b0;
    clear = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("startclear_busy", busy, 0);
    end
    check_idle_state("startclear");

    tick_always = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 4) == 0) do_clear();
      do_round(2'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0) begin
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    check_idle_state("random");
    tick_always = 1'b1;

    // reset during SHOW_OFF
    do_round(2'd1);
    for (int n = 0; n < 200 && led == 3'b000; n++) @(negedge clk);
    for (int n = 0; n < 200 && led != 3'b000; n++) @(negedge clk);
    check("reached_show_off", (led == 3'b000) && busy, 1);
    reset = 1'b0;
    model_pat.delete();
    exp_led.delete();
    exp_round.delete();
    round_active = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_led", led, 0);
    check("abort_seq_len", seq_len, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    $display("[TB] reset during playback");
    do_round(2'd2);
    check_idle_state("after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
